ay_psg_core: RTL and testbench
==============================

// Module: ay_psg_core
// PURPOSE
//  AY-3-8912 compatible PSG core: 16-register file, 3 tone generators, noise LFSR, envelope
//  generator and log volume DAC table. Produces three unsigned 12-bit channel levels
//  (ChA/ChB/ChC) that feed the audio mixer / sigma-delta DAC stage directly downstream.
//  Register access comes from the CPU/PPI bus glue; sound timing is driven by ClkEn (1 MHz).
// PARAMETERS
//  TONE_DIV_LOG2  3  tone tick = every 2**TONE_DIV_LOG2 ClkEn pulses (8 => tone f = ClkEn/(16*TP))
//  VOL_W          12 width of channel outputs; table below is for 12, other widths not supported
// PORTS
//  Clk      in   1  system clock
//  Reset    in   1  synchronous, active-high reset
//  ClkEn    in   1  AY master-clock enable, one Clk wide
//  RegAddr  in   4  register select
//  RegDin   in   8  write data
//  RegWe    in   1  write strobe, one Clk wide
//  RegDout  out  8  read data for RegAddr (combinational)
//  IoaIn    in   8  port A input pins (keyboard rows)
//  IoaOut   out  8  port A output latch (PSG_IOA_EN only; else 8'hFF)
//  ChA      out  12 channel A level
//  ChB      out  12 channel B level
//  ChC      out  12 channel C level
// BEHAVIOUR
//  - Reset: R0..R15=0, tone/noise/env counters=0, tone outputs=0, LFSR=17'h00001, env step=0,
//    ChA/B/C=0, IoaOut=8'hFF. Reset mid-operation aborts everything next Clk.
//  - Writes: RegWe latches RegDin into R[RegAddr] on that Clk, independent of ClkEn.
//    Unused bits stored as 0: R1/R3/R5/R13 4b, R6 5b, R8-R10 5b. RegDout returns masked value.
//  - Tick gen: ToneTick every 8 ClkEn pulses; NoiseTick/EnvTick every 16 ClkEn pulses.
//  - Tone x (12b TP, 0 treated as 1): on ToneTick cnt++; if cnt+1 >= TP: cnt<=0, toggle tone.
//    TP lowered below cnt => wraps on next tick (no 4096-count stall).
//  - Noise (5b NP, 0 as 1): same counter rule on NoiseTick; on wrap LFSR <= {b0^b3, lfsr[16:1]};
//    noise bit = lfsr[0].
//  - Envelope (16b EP, 0 as 1): counter on EnvTick; on wrap step++ (0..15). Level = ATT ? step
//    : 15-step. After step 15: CONT=0 -> hold 0; HOLD=1 -> hold (ALT ? inverted : last) level;
//    ALT=1 -> invert ATT, step<=0; else step<=0. Write to R13 restarts: step=0, cnt=0, holding
//    cleared; a write coinciding with an EnvTick wins over the tick.
//  - Channel gate = (tone | R7 tone-disable) & (noise | R7 noise-disable); R7 bit=1 disables.
//  - Volume: vol = R8..R10 bit4 ? env level : bits[3:0]; Ch = gate ? TABLE[vol] : 0.
//    TABLE 0..15: 0,32,45,64,91,128,181,256,362,512,724,1024,1448,2048,2896,4095.
//  - Ch outputs registered; update 1 Clk after any gate/vol change (latency 1 Clk).
//  - Sum of two channels <= 8190, fits downstream 13-bit mixer without overflow.
// CONFIGURATION
//  PSG_IOA_EN defined: R7 bit6=1 makes port A output; R14 write drives IoaOut when output,
//    IoaOut=8'hFF when input; R14 read returns R14 if output else IoaIn.
//  PSG_IOA_EN undefined: IoaOut=8'hFF constant; R14 read returns IoaIn; R14 writes ignored;
//    R15 reads 8'hFF in both builds.
// TESTING
//  1 Reset, R7=8'h3E, R0=1, R8=15, ClkEn every Clk -> ChA toggles 0/4095 every 8 Clk; ChB=ChC=0.
//  2 R0=0 vs R0=1 -> identical ChA waveforms; R1=8'hFF read back -> 8'h0F.
//  3 R7=8'h37 (noise A only), R6=1, R8=15 -> ChA follows LFSR bit0, first 17 bits match model.
//  4 R11=1,R12=0,R8=16,R7=8'h3E+tone off, R13=8 -> ChA steps 4095..0 each 16 ClkEn, repeats;
//    R13=9 -> ramps down once then holds 0; R13=11 -> ramps down then holds 4095.
//  5 Write R13 coincident with EnvTick -> step=0 on next cycle; Reset mid-ramp -> ChA=0 next Clk.
//  6 PSG_IOA_EN: R7=8'h40, R14=8'h5A -> IoaOut=8'h5A; R7=0 -> IoaOut=8'hFF, R14 reads IoaIn.

Source files
------------

// File: rtl/ay_psg_core.sv
// ---------------------------------------------------------------------------
// ay_psg_core -- AY-3-8912 compatible programmable sound generator core.
//
// Contains a 16-entry register file, three square-wave tone generators, a
// 17-bit noise LFSR, an envelope generator and the logarithmic volume table.
// Each channel produces an unsigned 12-bit level for the downstream mixer.
// The sum of any two channels is at most 8190, which fits a 13-bit mixer.
//
// Build option:
//   PSG_IOA_EN  When defined, I/O port A works. R7 bit6 = 1 makes the port an
//               output, and R14 then drives IoaOut. When undefined, IoaOut is
//               fixed at 8'hFF, R14 writes are dropped and R14 reads return
//               IoaIn.
//
// Ports:
//   Clk      system clock
//   Reset    synchronous, active-high reset
//   ClkEn    AY master-clock enable (1 MHz), one Clk wide
//   RegAddr  register select
//   RegDin   register write data
//   RegWe    register write strobe, one Clk wide, independent of ClkEn
//   RegDout  combinational read data for RegAddr (unused bits read as 0)
//   IoaIn    port A input pins
//   IoaOut   port A output latch (8'hFF when the port is an input)
//   ChA/B/C  registered channel levels, one Clk after a gate/volume change
// ---------------------------------------------------------------------------
module ay_psg_core #(
  parameter int TONE_DIV_LOG2 = 3,
  parameter int VOL_W         = 12
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClkEn,
  input  logic [3:0]       RegAddr,
  input  logic [7:0]       RegDin,
  input  logic             RegWe,
  output logic [7:0]       RegDout,
  input  logic [7:0]       IoaIn,
  output logic [7:0]       IoaOut,
  output logic [VOL_W-1:0] ChA,
  output logic [VOL_W-1:0] ChB,
  output logic [VOL_W-1:0] ChC
);

  localparam int PRESC_W = TONE_DIV_LOG2 + 1;

  // Register file: bits a register does not implement are stored as 0.
  function automatic logic [7:0] wr_mask(input logic [3:0] addr);
    case (addr)
      4'd1, 4'd3, 4'd5, 4'd13: wr_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: wr_mask = 8'h1F;
      default:                 wr_mask = 8'hFF;
    endcase
  endfunction

  logic [7:0] regs [16];
  logic       reg_wr_ok;

`ifdef PSG_IOA_EN
  assign reg_wr_ok = RegWe && (RegAddr != 4'd15);
`else
  assign reg_wr_ok = RegWe && (RegAddr < 4'd14);
`endif

  // NOTE: every register has an architectural reset value, so this array is
  // built from flops (not RAM) and is cleared element by element.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (reg_wr_ok) begin
      regs[RegAddr] <= RegDin & wr_mask(RegAddr);
    end
  end

  // Read mux. R14 is the port A pin/latch view; R15 (port B) is not bonded.
  // NOTE: assigning RegDout before the case means no path leaves it
  // unassigned, so no latch is inferred.
  always_comb begin
    RegDout = regs[RegAddr];
    case (RegAddr)
`ifdef PSG_IOA_EN
      4'd14:   RegDout = regs[7][6] ? regs[14] : IoaIn;
`else
      4'd14:   RegDout = IoaIn;
`endif
      4'd15:   RegDout = 8'hFF;
      default: ;
    endcase
  end

`ifdef PSG_IOA_EN
  assign IoaOut = regs[7][6] ? regs[14] : 8'hFF;
`else
  assign IoaOut = 8'hFF;
`endif

  // Tick generation. The low bits give the tone tick. The full prescaler
  // gives the noise/envelope tick, at half the tone rate.
  logic [PRESC_W-1:0] presc;
  logic               tone_tick;
  logic               slow_tick;

  assign tone_tick = ClkEn && (&presc[TONE_DIV_LOG2-1:0]);
  assign slow_tick = ClkEn && (&presc);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset)      presc <= '0;
    else if (ClkEn) presc <= presc + 1'b1;
  end

  // Noise generator. The period counter uses the same rule as the tones:
  // a ">=" compare, so lowering the period below the count wraps at once.
  logic [4:0]  noise_per;
  logic [4:0]  noise_cnt;
  logic [16:0] lfsr;

  assign noise_per = (regs[6][4:0] == 5'd0) ? 5'd1 : regs[6][4:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      noise_cnt <= '0;
      lfsr      <= 17'h00001;
    end else if (slow_tick) begin
      if ({1'b0, noise_cnt} + 6'd1 >= {1'b0, noise_per}) begin
        noise_cnt <= '0;
        lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end else begin
        noise_cnt <= noise_cnt + 5'd1;
      end
    end
  end

  // Envelope generator. A hold is represented as step = 15 with env_att
  // chosen so the level formula yields the held value (0 or 15). This keeps
  // the level path to a single expression.
  logic [15:0] env_per;
  logic [15:0] env_cnt;
  logic [3:0]  env_step;
  logic        env_att;
  logic        env_holding;
  logic [3:0]  env_level;
  logic        env_wr;
  logic        shp_cont, shp_alt, shp_hold;

  assign env_per   = ({regs[12], regs[11]} == 16'd0) ? 16'd1 : {regs[12], regs[11]};
  assign env_level = env_att ? env_step : (4'd15 - env_step);
  assign env_wr    = RegWe && (RegAddr == 4'd13);
  assign shp_cont  = regs[13][3];
  assign shp_alt   = regs[13][1];
  assign shp_hold  = regs[13][0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      env_cnt     <= '0;
      env_step    <= '0;
      env_att     <= 1'b0;
      env_holding <= 1'b0;
    end else if (env_wr) begin
      // A shape write restarts the envelope and takes priority over a
      // coincident tick.
      env_cnt     <= '0;
      env_step    <= '0;
      env_att     <= RegDin[2];
      env_holding <= 1'b0;
    end else if (slow_tick && !env_holding) begin
      if ({1'b0, env_cnt} + 17'd1 >= {1'b0, env_per}) begin
        env_cnt <= '0;
        if (env_step != 4'd15) begin
          env_step <= env_step + 4'd1;
        end else if (!shp_cont) begin
          env_holding <= 1'b1;
          env_att     <= 1'b0;
        end else if (shp_hold) begin
          env_holding <= 1'b1;
          env_att     <= shp_alt ? ~env_att : env_att;
        end else begin
          env_step <= '0;
          if (shp_alt) env_att <= ~env_att;
        end
      end else begin
        env_cnt <= env_cnt + 16'd1;
      end
    end
  end

  // Logarithmic volume table (about 3 dB per step).
  function automatic logic [11:0] vol_to_level(input logic [3:0] vol);
    case (vol)
      4'd0:    vol_to_level = 12'd0;
      4'd1:    vol_to_level = 12'd32;
      4'd2:    vol_to_level = 12'd45;
      4'd3:    vol_to_level = 12'd64;
      4'd4:    vol_to_level = 12'd91;
      4'd5:    vol_to_level = 12'd128;
      4'd6:    vol_to_level = 12'd181;
      4'd7:    vol_to_level = 12'd256;
      4'd8:    vol_to_level = 12'd362;
      4'd9:    vol_to_level = 12'd512;
      4'd10:   vol_to_level = 12'd724;
      4'd11:   vol_to_level = 12'd1024;
      4'd12:   vol_to_level = 12'd1448;
      4'd13:   vol_to_level = 12'd2048;
      4'd14:   vol_to_level = 12'd2896;
      default: vol_to_level = 12'd4095;
    endcase
  endfunction

  // Per-channel tone generator, mixer gate and output register.
  logic [VOL_W-1:0] ch_lvl [3];

  for (genvar g = 0; g < 3; g++) begin : g_chan
    logic [11:0]      tone_per;
    logic [11:0]      tone_cnt;
    logic             tone_q;
    logic             gate;
    logic [3:0]       vol;
    logic [VOL_W-1:0] lvl_q;

    assign tone_per = ({regs[2*g+1][3:0], regs[2*g]} == 12'd0) ?
                      12'd1 : {regs[2*g+1][3:0], regs[2*g]};

    always_ff @(posedge Clk) begin
      if (Reset) begin
        tone_cnt <= '0;
        tone_q   <= 1'b0;
      end else if (tone_tick) begin
        if ({1'b0, tone_cnt} + 13'd1 >= {1'b0, tone_per}) begin
          tone_cnt <= '0;
          tone_q   <= ~tone_q;
        end else begin
          tone_cnt <= tone_cnt + 12'd1;
        end
      end
    end

    // R7 bits are disables: a set bit forces that source's term high.
    assign gate = (tone_q | regs[7][g]) & (lfsr[0] | regs[7][g+3]);
    assign vol  = regs[8+g][4] ? env_level : regs[8+g][3:0];

    always_ff @(posedge Clk) begin
      if (Reset) lvl_q <= '0;
      else       lvl_q <= gate ? vol_to_level(vol) : '0;
    end

    assign ch_lvl[g] = lvl_q;
  end

  assign ChA = ch_lvl[0];
  assign ChB = ch_lvl[1];
  assign ChC = ch_lvl[2];

endmodule

// File: tb/tb_ay_psg_core.sv
// ---------------------------------------------------------------------------
// tb_ay_psg_core -- directed self-checking bench for ay_psg_core.
// Steps: reset state, register masking/readback, volume table, tone period
// and period-lowering wrap, noise LFSR sequence, envelope shapes, shape write
// versus envelope tick, reset mid-ramp, and port A behaviour for the build.
// ---------------------------------------------------------------------------
module tb_ay_psg_core;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ClkEn;
  logic [3:0]  RegAddr;
  logic [7:0]  RegDin;
  logic        RegWe;
  logic [7:0]  RegDout;
  logic [7:0]  IoaIn;
  logic [7:0]  IoaOut;
  logic [11:0] ChA, ChB, ChC;

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] vol_tab [16] = '{12'd0, 12'd32, 12'd45, 12'd64, 12'd91, 12'd128,
                                12'd181, 12'd256, 12'd362, 12'd512, 12'd724,
                                12'd1024, 12'd1448, 12'd2048, 12'd2896, 12'd4095};
  logic [16:0] lfsr_m;

  always #5 Clk = ~Clk;

  ay_psg_core dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .ClkEn   (ClkEn),
    .RegAddr (RegAddr),
    .RegDin  (RegDin),
    .RegWe   (RegWe),
    .RegDout (RegDout),
    .IoaIn   (IoaIn),
    .IoaOut  (IoaOut),
    .ChA     (ChA),
    .ChB     (ChB),
    .ChC     (ChC)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    RegAddr = a;
    RegDin  = d;
    RegWe   = 1'b1;
    step(1);
    RegWe   = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
    RegAddr = a;
    #1;
    check(tag, 16'(RegDout), 16'(exp));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    ClkEn = 1'b0;
    RegWe = 1'b0;
    step(2);
    Reset = 1'b0;
  endtask

  // Envelope on channel A only, EP = 1, all tone/noise disabled (gate = 1).
  task automatic env_setup(input logic [7:0] shape);
    do_reset();
    wr(4'd11, 8'd1);
    wr(4'd12, 8'd0);
    wr(4'd8,  8'h10);
    wr(4'd7,  8'h3F);
    wr(4'd13, shape);
    ClkEn = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; ClkEn = 1'b0; RegAddr = '0; RegDin = '0; RegWe = 1'b0; IoaIn = 8'hC3;

    // Reset state
    Reset = 1'b1;
    step(2);
    check("rst_cha", 16'(ChA), 16'd0);
    check("rst_chb", 16'(ChB), 16'd0);
    check("rst_chc", 16'(ChC), 16'd0);
    check("rst_ioa", 16'(IoaOut), 16'hFF);
    rd_check("rst_r0", 4'd0, 8'h00);
    rd_check("rst_r7", 4'd7, 8'h00);
    Reset = 1'b0;

    // Register masking and readback
    wr(4'd1, 8'hFF);  rd_check("rb_r1", 4'd1, 8'h0F);
    wr(4'd6, 8'hFF);  rd_check("rb_r6", 4'd6, 8'h1F);
    wr(4'd8, 8'hFF);  rd_check("rb_r8", 4'd8, 8'h1F);
    wr(4'd13, 8'hFF); rd_check("rb_r13", 4'd13, 8'h0F);
    wr(4'd2, 8'hAB);  rd_check("rb_r2", 4'd2, 8'hAB);
    rd_check("rb_r15", 4'd15, 8'hFF);
    wr(4'd14, 8'h5A); rd_check("rb_r14_in", 4'd14, 8'hC3);

    // Fixed volumes, one-Clk output latency
    do_reset();
    wr(4'd7, 8'h3F);
    wr(4'd8, 8'd7);
    check("vol_lat", 16'(ChA), 16'd0);
    wr(4'd9, 8'd1);
    check("vol_a7", 16'(ChA), 16'd256);
    wr(4'd10, 8'd10);
    step(1);
    check("vol_b1", 16'(ChB), 16'd32);
    check("vol_c10", 16'(ChC), 16'd724);

    // Tone A with TP = 1: toggles every 8 ClkEn
    do_reset();
    wr(4'd7, 8'h3E); wr(4'd0, 8'd1); wr(4'd8, 8'd15);
    ClkEn = 1'b1;
    step(8); check("t1_e8", 16'(ChA), 16'd0);
    step(1); check("t1_e9", 16'(ChA), 16'd4095);
    check("t1_chb", 16'(ChB), 16'd0);
    check("t1_chc", 16'(ChC), 16'd0);
    step(7); check("t1_e16", 16'(ChA), 16'd4095);
    step(1); check("t1_e17", 16'(ChA), 16'd0);

    // TP = 0 behaves as TP = 1
    do_reset();
    wr(4'd7, 8'h3E); wr(4'd0, 8'd0); wr(4'd8, 8'd15);
    ClkEn = 1'b1;
    step(8); check("t0_e8", 16'(ChA), 16'd0);
    step(1); check("t0_e9", 16'(ChA), 16'd4095);
    step(7); check("t0_e16", 16'(ChA), 16'd4095);
    step(1); check("t0_e17", 16'(ChA), 16'd0);

    // Tone B with TP = 3: first toggle on the third tone tick
    do_reset();
    wr(4'd7, 8'h3D); wr(4'd2, 8'd3); wr(4'd9, 8'd15);
    ClkEn = 1'b1;
    step(24); check("tp3_e24", 16'(ChB), 16'd0);
    step(1);  check("tp3_e25", 16'(ChB), 16'd4095);

    // Lowering TP below the running count wraps on the next tick
    do_reset();
    wr(4'd7, 8'h3D); wr(4'd2, 8'd100); wr(4'd9, 8'd15);
    ClkEn = 1'b1;
    step(48);
    ClkEn = 1'b0;
    wr(4'd2, 8'd2);
    ClkEn = 1'b1;
    step(8);  check("tpl_f8", 16'(ChB), 16'd0);
    step(1);  check("tpl_f9", 16'(ChB), 16'd4095);
    step(15); check("tpl_f24", 16'(ChB), 16'd4095);
    step(1);  check("tpl_f25", 16'(ChB), 16'd0);

    // Noise on channel A follows LFSR bit0
    do_reset();
    wr(4'd7, 8'h37); wr(4'd6, 8'd1); wr(4'd8, 8'd15);
    ClkEn = 1'b1;
    lfsr_m = 17'h00001;
    step(1);
    check("nz_0", 16'(ChA), lfsr_m[0] ? 16'd4095 : 16'd0);
    for (int k = 1; k <= 40; k++) begin
      step(16);
      lfsr_m = {lfsr_m[0] ^ lfsr_m[3], lfsr_m[16:1]};
      check($sformatf("nz_%0d", k), 16'(ChA), lfsr_m[0] ? 16'd4095 : 16'd0);
    end
    check("nz_chb", 16'(ChB), 16'd0);

    // Envelope shape 8: repeating ramp down
    env_setup(8'd8);
    step(1);
    check("e8_s0", 16'(ChA), 16'(vol_tab[15]));
    for (int k = 1; k < 16; k++) begin
      step(16);
      check($sformatf("e8_s%0d", k), 16'(ChA), 16'(vol_tab[15-k]));
    end
    step(16); check("e8_rep", 16'(ChA), 16'd4095);

    // Shape 9: ramp down once, hold 0
    env_setup(8'd9);
    step(241); check("e9_s15", 16'(ChA), 16'd0);
    step(16);  check("e9_hold1", 16'(ChA), 16'd0);
    step(32);  check("e9_hold2", 16'(ChA), 16'd0);

    // Shape 11: ramp down, hold 4095
    env_setup(8'd11);
    step(241); check("e11_s15", 16'(ChA), 16'd0);
    step(16);  check("e11_hold1", 16'(ChA), 16'd4095);
    step(32);  check("e11_hold2", 16'(ChA), 16'd4095);

    // Shape 4: ramp up once, then CONT=0 forces 0
    env_setup(8'd4);
    step(1);   check("e4_s0", 16'(ChA), 16'd0);
    step(240); check("e4_s15", 16'(ChA), 16'd4095);
    step(16);  check("e4_hold", 16'(ChA), 16'd0);

    // Shape 14: triangle (up then down)
    env_setup(8'd14);
    step(241); check("e14_top", 16'(ChA), 16'd4095);
    step(16);  check("e14_dn0", 16'(ChA), 16'd4095);
    step(16);  check("e14_dn1", 16'(ChA), 16'd2896);

    // Shape write coinciding with an envelope tick wins
    env_setup(8'd8);
    step(15);
    wr(4'd13, 8'd8);
    step(1);  check("coin_e17", 16'(ChA), 16'd4095);
    step(15); check("coin_e32", 16'(ChA), 16'd4095);
    step(1);  check("coin_e33", 16'(ChA), 16'd2896);

    // Reset mid-ramp clears outputs on the next Clk
    Reset = 1'b1;
    step(1);
    check("midrst_cha", 16'(ChA), 16'd0);
    rd_check("midrst_r8", 4'd8, 8'h00);
    Reset = 1'b0;

    // Port A
    do_reset();
    IoaIn = 8'h96;
    wr(4'd7, 8'h40);
    wr(4'd14, 8'h5A);
`ifdef PSG_IOA_EN
    check("ioa_out", 16'(IoaOut), 16'h5A);
    rd_check("ioa_rd_out", 4'd14, 8'h5A);
`else
    check("ioa_out", 16'(IoaOut), 16'hFF);
    rd_check("ioa_rd_out", 4'd14, 8'h96);
`endif
    wr(4'd7, 8'h00);
    check("ioa_in", 16'(IoaOut), 16'hFF);
    rd_check("ioa_rd_in", 4'd14, 8'h96);
    rd_check("ioa_r15", 4'd15, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
